control_filtro_pb200: RTL and testbench

Control unit for the time-multiplexed biquad low-pass datapath `filtropb200`. It sequences one sample per input tick. For each sample it drives the datapath's seven register enables and three operand-mux selects, then shifts the delay line and flags the output valid. It sits between the sample-rate tick generator and the datapath, which it drives directly and does not read back.

---
 rtl/control_filtro_pb200.sv | 178 +++++++++++++++++
 tb/tb_control_filtro_pb200.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/control_filtro_pb200.sv
// rtl/control_filtro_pb200.sv - sequencer for the time-multiplexed biquad low-pass datapath
module control_filtro_pb200 #(
  parameter int ARIT_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_muestra,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [1:0] selmuxC,
  output logic [2:0] selmuxZ,
  output logic       ocupado,
  output logic       listo,
  output logic       sobrecarga
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_SHIFT
  } estado_t;

  // Last wait-counter value before WRITE; unused when the unit has a single-cycle latency.
  localparam logic [2:0] CNT_FIN    = 3'(ARIT_LAT - 2);
  localparam bit         SIN_ESPERA = (ARIT_LAT == 1);

  estado_t    estado, estado_n;
  logic [2:0] op, op_n;
  logic [2:0] cnt, cnt_n;
  logic       acepta;

  logic       en1_n, en2_n, en3_n, en4_n, en5_n, en6_n, en7_n;
  logic [2:0] sel_s_n, sel_z_n;
  logic [1:0] sel_c_n;
  logic       ocupado_n, listo_n, sobrecarga_n;

  // A new sample may only start when idle or while the previous one is shifting out.
  assign acepta = (estado == S_IDLE) || (estado == S_SHIFT);

  // State, op index and wait counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado <= S_IDLE;
      op     <= 3'd0;
      cnt    <= 3'd0;
    end else begin
      estado <= estado_n;
      op     <= op_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state logic: ISSUE -> WAIT (ARIT_LAT-1 cycles) -> WRITE per op, five ops, then SHIFT.
  always_comb begin
    estado_n = estado;
    op_n     = op;
    cnt_n    = cnt;
    case (estado)
      S_IDLE: begin
        if (tick_muestra) begin
          estado_n = S_ISSUE;
          op_n     = 3'd0;
          cnt_n    = 3'd0;
        end
      end
      S_ISSUE: begin
        cnt_n    = 3'd0;
        estado_n = SIN_ESPERA ? S_WRITE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CNT_FIN) estado_n = S_WRITE;
        else                cnt_n    = cnt + 3'd1;
      end
      S_WRITE: begin
        if (op == 3'd4) begin
          estado_n = S_SHIFT;
        end else begin
          estado_n = S_ISSUE;
          op_n     = op + 3'd1;
        end
      end
      S_SHIFT: begin
        op_n     = 3'd0;
        cnt_n    = 3'd0;
        estado_n = tick_muestra ? S_ISSUE : S_IDLE;
      end
      default: begin
        estado_n = S_IDLE;
        op_n     = 3'd0;
        cnt_n    = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    en1_n        = 1'b0;
    en2_n        = 1'b0;
    en3_n        = 1'b0;
    en4_n        = 1'b0;
    en5_n        = 1'b0;
    en6_n        = 1'b0;
    en7_n        = 1'b0;
    sel_s_n      = 3'd0;
    sel_c_n      = 2'd0;
    sel_z_n      = 3'd0;
    listo_n      = 1'b0;
    ocupado_n    = (estado_n != S_IDLE);
    sobrecarga_n = sobrecarga | (tick_muestra & ~acepta);
    if (estado_n == S_ISSUE || estado_n == S_WAIT || estado_n == S_WRITE) begin
      case (op_n)
        3'd0:    begin sel_s_n = 3'd1; sel_c_n = 2'd0; sel_z_n = 3'd1; end
        3'd1:    begin sel_s_n = 3'd2; sel_c_n = 2'd1; sel_z_n = 3'd2; end
        3'd2:    begin sel_s_n = 3'd0; sel_c_n = 2'd2; sel_z_n = 3'd0; end
        3'd3:    begin sel_s_n = 3'd1; sel_c_n = 2'd3; sel_z_n = 3'd3; end
        3'd4:    begin sel_s_n = 3'd2; sel_c_n = 2'd2; sel_z_n = 3'd4; end
        default: begin sel_s_n = 3'd0; sel_c_n = 2'd0; sel_z_n = 3'd0; end
      endcase
    end
    if (estado_n == S_WRITE) begin
      case (op_n)
        3'd0:    en5_n = 1'b1;
        3'd1:    en2_n = 1'b1;
        3'd2:    en6_n = 1'b1;
        3'd3:    en7_n = 1'b1;
        3'd4:    en1_n = 1'b1;
        default: ;
      endcase
    end
    if (estado_n == S_SHIFT) begin
      en3_n   = 1'b1;
      en4_n   = 1'b1;
      listo_n = 1'b1;
    end
  end

  // Registered outputs; reset wins over any tick in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en1        <= 1'b0;
      en2        <= 1'b0;
      en3        <= 1'b0;
      en4        <= 1'b0;
      en5        <= 1'b0;
      en6        <= 1'b0;
      en7        <= 1'b0;
      selmuxS    <= 3'd0;
      selmuxC    <= 2'd0;
      selmuxZ    <= 3'd0;
      ocupado    <= 1'b0;
      listo      <= 1'b0;
      sobrecarga <= 1'b0;
    end else begin
      en1        <= en1_n;
      en2        <= en2_n;
      en3        <= en3_n;
      en4        <= en4_n;
      en5        <= en5_n;
      en6        <= en6_n;
      en7        <= en7_n;
      selmuxS    <= sel_s_n;
      selmuxC    <= sel_c_n;
      selmuxZ    <= sel_z_n;
      ocupado    <= ocupado_n;
      listo      <= listo_n;
      sobrecarga <= sobrecarga_n;
    end
  end

endmodule

// File: tb/tb_control_filtro_pb200.sv
// tb/tb_control_filtro_pb200.sv - self-checking bench for control_filtro_pb200
module tb_control_filtro_pb200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick1 = 1'b0;
  logic       tick2 = 1'b0;
  logic [6:0] en_a, en_b;
  logic [2:0] s_a, s_b, z_a, z_b;
  logic [1:0] c_a, c_b;
  logic       oc_a, oc_b, li_a, li_b, so_a, so_b;

  int vectors = 0;
  int miss    = 0;

  always #5 clk = ~clk;

  control_filtro_pb200 #(.ARIT_LAT(1)) u1 (
    .clk(clk), .reset(reset), .tick_muestra(tick1),
    .en1(en_a[0]), .en2(en_a[1]), .en3(en_a[2]), .en4(en_a[3]),
    .en5(en_a[4]), .en6(en_a[5]), .en7(en_a[6]),
    .selmuxS(s_a), .selmuxC(c_a), .selmuxZ(z_a),
    .ocupado(oc_a), .listo(li_a), .sobrecarga(so_a)
  );

  control_filtro_pb200 #(.ARIT_LAT(2)) u2 (
    .clk(clk), .reset(reset), .tick_muestra(tick2),
    .en1(en_b[0]), .en2(en_b[1]), .en3(en_b[2]), .en4(en_b[3]),
    .en5(en_b[4]), .en6(en_b[5]), .en7(en_b[6]),
    .selmuxS(s_b), .selmuxC(c_b), .selmuxZ(z_b),
    .ocupado(oc_b), .listo(li_b), .sobrecarga(so_b)
  );

  // packed view: [17:11]=en7..en1, [10:8]=S, [7:6]=C, [5:3]=Z, [2]=ocupado, [1]=listo, [0]=sobrecarga
  logic [17:0] pk1, pk2;
  assign pk1 = {en_a, s_a, c_a, z_a, oc_a, li_a, so_a};
  assign pk2 = {en_b, s_b, c_b, z_b, oc_b, li_b, so_b};

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
    end
  endtask

  // operand triple per op as {S,C,Z} and the enable index raised in its write cycle
  logic [7:0] selt  [0:4] = '{{3'd1, 2'd0, 3'd1}, {3'd2, 2'd1, 3'd2}, {3'd0, 2'd2, 3'd0},
                              {3'd1, 2'd3, 3'd3}, {3'd2, 2'd2, 3'd4}};
  int         enidx [0:4] = '{4, 1, 5, 6, 0};

  // expected outputs from the position p within a sample sequence (0 = idle)
  function automatic logic [17:0] modelo(int p, int lat, logic sob);
    int n = 5 * (1 + lat) + 1;
    int op, fase;
    logic [17:0] v = '0;
    v[0] = sob;
    if (p == 0) return v;
    v[2] = 1'b1;
    if (p == n) begin
      v[1] = 1'b1; v[13] = 1'b1; v[14] = 1'b1;
      return v;
    end
    op = (p - 1) / (1 + lat);
    fase = (p - 1) % (1 + lat);
    v[10:3] = selt[op];
    if (fase == lat) v[11 + enidx[op]] = 1'b1;
    return v;
  endfunction

  function automatic int sig(int p, int lat, logic t);
    int n = 5 * (1 + lat) + 1;
    if (p == 0 || p == n) return t ? 1 : 0;
    return p + 1;
  endfunction

  int   p1 = 0, p2 = 0;
  logic s1 = 1'b0, s2 = 1'b0;
  bit   armado = 1'b0;

  always @(posedge clk) begin
    armado = 1'b1;
    if (!reset) begin
      p1 = 0; p2 = 0; s1 = 1'b0; s2 = 1'b0;
    end else begin
      if (tick1 && !(p1 == 0 || p1 == 11)) s1 = 1'b1;
      if (tick2 && !(p2 == 0 || p2 == 16)) s2 = 1'b1;
      p1 = sig(p1, 1, tick1);
      p2 = sig(p2, 2, tick2);
    end
  end

  // datapath stand-in driven by u1: -a1=0.5, others 0, uk=1.0
  real fk = 0.0, fk1 = 0.0, fk2 = 0.0, yk = 0.0, ac1 = 0.0, ac2 = 0.0, ac3 = 0.0;
  real sv, cv, zv, r;
  always @(posedge clk) begin
    case (s_a)
      3'd0: sv = fk; 3'd1: sv = fk1; 3'd2: sv = fk2; 3'd3: sv = 1.0; default: sv = yk;
    endcase
    cv = (c_a == 2'd0) ? 0.5 : 0.0;
    case (z_a)
      3'd1: zv = 1.0; 3'd2: zv = ac1; 3'd3: zv = ac2; 3'd4: zv = ac3; default: zv = 0.0;
    endcase
    r = sv * cv + zv;
    if (en_a[0]) yk <= r;
    if (en_a[1]) fk <= r;
    if (en_a[2]) fk1 <= fk;
    if (en_a[3]) fk2 <= fk1;
    if (en_a[4]) ac1 <= r;
    if (en_a[5]) ac2 <= r;
    if (en_a[6]) ac3 <= r;
  end

  int nlisto = 0;
  int fk_x4  [1:3] = '{4, 6, 7};
  int fk1_x4 [1:3] = '{0, 4, 6};

  always @(negedge clk) begin
    if (armado) begin
      chk("u1 outputs vs model", int'(pk1), int'(modelo(p1, 1, s1)));
      chk("u2 outputs vs model", int'(pk2), int'(modelo(p2, 2, s2)));
      if (li_a) begin
        nlisto++;
        if (nlisto <= 3) begin
          chk($sformatf("fk x4 at listo %0d", nlisto), $rtoi(fk * 4.0), fk_x4[nlisto]);
          chk($sformatf("fk1 x4 at listo %0d", nlisto), $rtoi(fk1 * 4.0), fk1_x4[nlisto]);
        end
      end
    end
  end

  logic [17:0] h1 [0:39];
  logic [17:0] h2 [0:39];
  logic [6:0]  enmap [0:12] = '{7'b0, 7'b0, 7'b0010000, 7'b0, 7'b0000010, 7'b0, 7'b0100000,
                               7'b0, 7'b1000000, 7'b0, 7'b0000001, 7'b0001100, 7'b0};

  // cycle c: record outputs, then drive the inputs sampled at the edge closing cycle c
  task automatic run(input int n, input logic [39:0] t1, input logic [39:0] t2, input logic [39:0] rm);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      h1[c] = pk1;
      h2[c] = pk2;
      tick1 = t1[c];
      tick2 = t2[c];
      reset = ~rm[c];
    end
  endtask

  task automatic chk_map(input string tag);
    for (int c = 1; c <= 12; c++)
      chk($sformatf("%s en map c%0d", tag, c), int'(h1[c][17:11]), int'(enmap[c]));
  endtask

  initial begin
    // reset held two cycles with ticks during it
    run(6, 40'b11, 40'b10, 40'b11);
    chk("reset u1 c3", int'(h1[3]), 0);
    chk("reset u1 c5", int'(h1[5]), 0);
    chk("reset u2 c5", int'(h2[5]), 0);

    // single tick on both
    run(18, 40'b1, 40'b1, 40'b0);
    chk_map("single");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sel issue op%0d", k + 1), int'(h1[2 * k + 1][10:3]), int'(selt[k]));
      chk($sformatf("sel write op%0d", k + 1), int'(h1[2 * k + 2][10:3]), int'(selt[k]));
    end
    chk("ocupado c1", int'(h1[1][2]), 1);
    chk("ocupado c11", int'(h1[11][2]), 1);
    chk("ocupado c12", int'(h1[12][2]), 0);
    chk("listo c10", int'(h1[10][1]), 0);
    chk("listo c11", int'(h1[11][1]), 1);
    chk("sel shift", int'(h1[11][10:3]), 0);
    chk("lat2 en5 c3", int'(h2[3][17:11]), 7'b0010000);
    chk("lat2 en2 c6", int'(h2[6][17:11]), 7'b0000010);
    chk("lat2 en1 c15", int'(h2[15][17:11]), 7'b0000001);
    chk("lat2 shift c16", int'(h2[16][17:11]), 7'b0001100);
    chk("lat2 listo c16", int'(h2[16][1]), 1);
    chk("lat2 ocupado c17", int'(h2[17][2]), 0);

    // overrun: extra tick at cycle 5
    run(13, 40'b100001, 40'b100001, 40'b0);
    chk_map("overrun");
    chk("sob c5", int'(h1[5][0]), 0);
    chk("sob c6", int'(h1[6][0]), 1);
    chk("sob c12", int'(h1[12][0]), 1);

    // reset, then back-to-back ticks with the second in the shift cycle
    run(27, (40'b1 << 2) | (40'b1 << 13), 40'b0, 40'b1);
    chk("post reset c1", int'(h1[1]), 0);
    chk("b2b shift c13", int'(h1[13][17:11]), 7'b0001100);
    chk("b2b ocupado c14", int'(h1[14][2]), 1);
    chk("b2b en5 c15", int'(h1[15][17:11]), 7'b0010000);
    chk("b2b listo c24", int'(h1[24][1]), 1);
    chk("b2b sob c24", int'(h1[24][0]), 0);

    // reset low in cycle 6 of a sequence
    run(10, 40'b1, 40'b1, 40'b1 << 6);
    chk("abort en6 c6", int'(h1[6][17:11]), 7'b0100000);
    chk("abort u1 c7", int'(h1[7]), 0);
    chk("abort u2 c7", int'(h2[7]), 0);
    chk("abort u1 c9", int'(h1[9]), 0);

    // a full sequence after the abort
    run(13, 40'b1, 40'b0, 40'b0);
    chk_map("after abort");
    chk("after abort listo c11", int'(h1[11][1]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
